// File: rtl/adc_multi_capture.sv
// N-channel ADC capture engine: registered inputs, optional level-crossing trigger,
// decimated storage of DEPTH samples per channel and a 1-cycle-latency read port.
module adc_multi_capture #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned DECIM_W = 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_CH*DATA_W-1:0] ad_data,
  input  logic [NUM_CH-1:0]        ad_otr,
  output logic                     ad_oe,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     trig_mode,
  input  logic [2:0]               trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic [DECIM_W-1:0]       decim,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH-1:0]        otr_flags,
  input  logic                     rd_en,
  input  logic [2:0]               rd_ch,
  input  logic [AW-1:0]            rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t                    state_q;
  logic [NUM_CH*DATA_W-1:0]  s_data_q;
  logic [NUM_CH-1:0]         s_otr_q;
  logic                      busy_q;
  logic                      done_q;
  logic [NUM_CH-1:0]         otr_q;
  logic [AW-1:0]             wr_idx_q;
  logic [DECIM_W-1:0]        dec_cnt_q;
  logic [DATA_W-1:0]         prev_q;
  logic                      prev_valid_q;
  logic                      trig_mode_q;
  logic [2:0]                trig_ch_q;
  logic [DATA_W-1:0]         trig_lvl_q;
  logic [DECIM_W-1:0]        decim_q;
  logic [DATA_W-1:0]         rd_data_q;
  logic                      rd_valid_q;

  logic [DATA_W-1:0]         ram_q [NUM_CH][DEPTH];

  logic [DATA_W-1:0]         trig_smp_c;
  logic                      trig_hit_c;
  logic                      wr_en_c;
  logic [DATA_W-1:0]         rd_word_c;

  assign ad_oe     = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign otr_flags = otr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  // Trigger channel sample; an out-of-range channel reads as zero and never crosses.
  always_comb begin
    trig_smp_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (trig_ch_q == 3'(c)) trig_smp_c = s_data_q[c*DATA_W +: DATA_W];
    end
  end

  assign trig_hit_c = prev_valid_q && (prev_q < trig_lvl_q) && (trig_smp_c >= trig_lvl_q);
  assign wr_en_c    = ((state_q == S_CAPTURE) && (dec_cnt_q == '0)) ||
                      ((state_q == S_ARM) && trig_mode_q && trig_hit_c);

  always_comb begin
    rd_word_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == 3'(c)) rd_word_c = ram_q[c][rd_addr];
    end
  end

  // Sample RAM; contents survive reset. A triggered write lands at wr_idx 0.
  always_ff @(posedge sys_clk) begin
    if (wr_en_c) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ram_q[c][wr_idx_q] <= s_data_q[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_word_c;
    end
  end

  // Capture control FSM with registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      s_data_q     <= '0;
      s_otr_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      otr_q        <= '0;
      wr_idx_q     <= '0;
      dec_cnt_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_mode_q  <= 1'b0;
      trig_ch_q    <= '0;
      trig_lvl_q   <= '0;
      decim_q      <= '0;
    end else begin
      s_data_q <= ad_data;
      s_otr_q  <= ad_otr;
      done_q   <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q      <= S_ARM;
              busy_q       <= 1'b1;
              otr_q        <= '0;
              wr_idx_q     <= '0;
              prev_valid_q <= 1'b0;
              trig_mode_q  <= trig_mode;
              trig_ch_q    <= trig_ch;
              trig_lvl_q   <= trig_level;
              decim_q      <= decim;
            end
          end
          S_ARM: begin
            otr_q        <= otr_q | s_otr_q;
            prev_q       <= trig_smp_c;
            prev_valid_q <= 1'b1;
            if (!trig_mode_q) begin
              state_q   <= S_CAPTURE;
              dec_cnt_q <= '0;
            end else if (trig_hit_c) begin
              // Sample 0 was written this cycle; continue one step into the decimation cycle.
              state_q   <= S_CAPTURE;
              wr_idx_q  <= AW'(1);
              dec_cnt_q <= (decim_q == '0) ? '0 : DECIM_W'(1);
            end
          end
          S_CAPTURE: begin
            otr_q     <= otr_q | s_otr_q;
            dec_cnt_q <= (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + DECIM_W'(1);
            if (dec_cnt_q == '0) begin
              if (wr_idx_q == AW'(DEPTH - 1)) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                wr_idx_q <= wr_idx_q + AW'(1);
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_multi_capture.sv
// Scoreboard bench for adc_multi_capture: expected RAM words and done times are
// predicted at start from the known input waveform and checked as the DUT answers.
module tb_adc_multi_capture;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DATA_W  = 10;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DECIM_W = 8;
  localparam int unsigned AW      = 4;

  logic                     clk = 1'b0;
  logic                     sys_rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] ad_data = '0;
  logic [NUM_CH-1:0]        ad_otr = '0;
  logic                     ad_oe;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     trig_mode = 1'b0;
  logic [2:0]               trig_ch = '0;
  logic [DATA_W-1:0]        trig_level = '0;
  logic [DECIM_W-1:0]       decim = '0;
  logic                     busy;
  logic                     done;
  logic [NUM_CH-1:0]        otr_flags;
  logic                     rd_en = 1'b0;
  logic [2:0]               rd_ch = '0;
  logic [AW-1:0]            rd_addr = '0;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit ramp_on = 1'b0;
  int ramp_base = 0;

  logic [DATA_W-1:0] exp_mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] rd_q [$];
  int                done_q [$];

  adc_multi_capture #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .ad_data(ad_data), .ad_otr(ad_otr), .ad_oe(ad_oe),
    .start(start), .abort(abort), .trig_mode(trig_mode), .trig_ch(trig_ch),
    .trig_level(trig_level), .decim(decim), .busy(busy), .done(done),
    .otr_flags(otr_flags), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Input waveform: value sampled at posedge number n.
  function automatic logic [DATA_W-1:0] smp(input int c, input int n);
    if (c == 0) return DATA_W'(n);
    if (ramp_on) return (n >= ramp_base) ? DATA_W'(500 + n - ramp_base) : DATA_W'(100);
    return DATA_W'(n * 7 + 3);
  endfunction

  always @(posedge clk) begin
    #2;
    ad_data = {smp(1, cyc + 1), smp(0, cyc + 1)};
  end

  // Output monitor: pops the scoreboard queues as the DUT answers.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) check("done_unexpected", cyc, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic do_start(input bit mode, input int ch, input int lvl, input int d);
    int t;
    int x;
    @(negedge clk);
    trig_mode  = mode;
    trig_ch    = 3'(ch);
    trig_level = DATA_W'(lvl);
    decim      = DECIM_W'(d);
    start      = 1'b1;
    t = cyc + 1;
    x = t + 1;
    if (mode) begin
      for (int n = t + 1; n < t + 200; n++) begin
        if (smp(ch, n - 1) < DATA_W'(lvl) && smp(ch, n) >= DATA_W'(lvl)) begin
          x = n;
          break;
        end
      end
    end
    for (int c = 0; c < int'(NUM_CH); c++)
      for (int k = 0; k < int'(DEPTH); k++)
        exp_mem[c][k] = smp(c, x + k * (d + 1));
    done_q.push_back(x + 1 + (int'(DEPTH) - 1) * (d + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n0 = done_cnt;
    int i = 0;
    while (done_cnt == n0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == n0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_pulse_len", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
  endtask

  task automatic read_all(input int ch);
    for (int a = 0; a < int'(DEPTH); a++) begin
      @(negedge clk);
      rd_en   = 1'b1;
      rd_ch   = 3'(ch);
      rd_addr = AW'(a);
      rd_q.push_back((ch < int'(NUM_CH)) ? exp_mem[ch][a] : '0);
    end
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
  endtask

  initial begin
    int n0;
    #100_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_otr", 32'(otr_flags), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("ad_oe", 32'(ad_oe), 0);

    // Immediate capture; a second start while busy must not restart it.
    do_start(1'b0, 0, 0, 0);
    check("busy_arm", 32'(busy), 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_capture", 32'(busy), 1);
    wait_done(100);
    read_all(0);
    read_all(1);

    // Level-crossing trigger on ch1 at 512.
    @(negedge clk);
    ramp_on   = 1'b1;
    ramp_base = cyc + 4;
    do_start(1'b1, 1, 512, 0);
    check("trig_exp_idx0", 32'(exp_mem[1][0]), 512);
    wait_done(200);
    read_all(1);
    read_all(0);
    read_all(3);
    ramp_on = 1'b0;

    // Decimation by 4.
    do_start(1'b0, 0, 0, 3);
    wait_done(200);
    read_all(0);

    // Sticky over-range flag during a decimated capture.
    do_start(1'b0, 0, 0, 1);
    repeat (8) @(negedge clk);
    ad_otr = 2'b10;
    @(negedge clk);
    ad_otr = 2'b00;
    wait_done(100);
    check("otr_after_done", 32'(otr_flags), 2);
    repeat (3) @(negedge clk);
    check("otr_held", 32'(otr_flags), 2);

    // Abort mid-capture: flags cleared by the re-arm, no done afterwards.
    do_start(1'b0, 0, 0, 0);
    check("otr_cleared_rearm", 32'(otr_flags), 0);
    repeat (8) @(negedge clk);
    abort = 1'b1;
    done_q.delete();
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    n0 = done_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt, n0);
    do_start(1'b0, 0, 0, 0);
    wait_done(100);
    read_all(1);

    // Reset in the middle of a capture with nonzero outputs.
    @(negedge clk);
    rd_en = 1'b1; rd_ch = 3'd0; rd_addr = AW'(5);
    rd_q.push_back(exp_mem[0][5]);
    @(negedge clk);
    rd_en = 1'b0;
    do_start(1'b0, 0, 0, 0);
    ad_otr = 2'b01;
    @(negedge clk);
    ad_otr = 2'b00;
    repeat (3) @(negedge clk);
    check("pre_rst_otr", 32'(otr_flags), 1);
    sys_rst = 1'b1;
    done_q.delete();
    @(negedge clk);
    sys_rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_otr", 32'(otr_flags), 0);
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_rd_data", 32'(rd_data), 0);
    n0 = done_cnt;
    repeat (40) @(negedge clk);
    check("rst_no_done", done_cnt, n0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
